param_serializer: RTL and testbench
===================================

Name: param_serializer

Overview:
- Transmit end of the serial parameter-load link. It serializes NUM_WORDS signed words of WORD_WIDTH bits into one frame on three wires: data, serial clock and trigger.
- The wire format is the one the parameter deserializer consumes: data is sampled on the serial-clock rising edge, and a trigger marks frame completion.
- It is used by the host-side or loopback FPGA to push servo and sweep coefficients, and by the bench as the stimulus source for the deserializer.

Parameters:
- NUM_WORDS, 12, number of words per frame.
- WORD_WIDTH, 35, bits per word.
- CLKDIV, 8, clk_in cycles per serial bit. Must be even and >=2.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  synchronous reset, active-low.
- words_in  input  NUM_WORDS*WORD_WIDTH  flat word bus; word k occupies bits [(k+1)*WORD_WIDTH-1 : k*WORD_WIDTH].
- start_in  input  1  frame request, level or pulse.
- busy_out  output  1  high while a frame is in progress.
- done_out  output  1  one-cycle pulse when a frame completes.
- sdata_out  output  1  serial data.
- sclk_out  output  1  serial clock.
- trig_out  output  1  frame-complete trigger, high for exactly one serial-clock period.

Behaviour:
- Reset: when rst_in=0 at a clk_in edge, all outputs are 0 and the FSM is IDLE on the next cycle, including mid-frame. A partially sent frame is abandoned and sclk_out returns low with no further edges.
- FSM states: IDLE, SHIFT, TRIG, DONE.
- IDLE:
  - Outputs idle low.
  - start_in=1 at edge T: words_in is latched into the shift register and the FSM goes to SHIFT.
  - busy_out=1 from T+1.
  - start_in is ignored whenever busy_out=1.
- Bit timing:
  - Each bit period is CLKDIV cycles: sclk_out=0 for the first CLKDIV/2 cycles, then 1 for the last CLKDIV/2.
  - sdata_out changes only at the start of a bit period (sclk falling edge or the idle-low level), so it is stable across the rising edge.
  - The first bit appears at cycle T+1.
- Bit order:
  - Word 0 is sent first, then word 1, up to word NUM_WORDS-1.
  - Each word is sent MSB first.
  - Total data bits NB = NUM_WORDS*WORD_WIDTH.
- SHIFT:
  - A divider counter counts 0..CLKDIV-1 and a bit counter counts 0..NB-1.
  - At the end of bit NB-1 the FSM goes to TRIG.
- TRIG:
  - One full extra bit period with the same low-then-high sclk_out shape.
  - sdata_out=0 and trig_out=1 for all CLKDIV cycles.
  - The FSM then goes to DONE.
- DONE:
  - Lasts one cycle: done_out=1, busy_out=0, sclk_out=0, trig_out=0.
  - The FSM returns to IDLE.
  - A start_in=1 during this cycle is accepted (busy_out is already low), which permits back-to-back frames with a 1-cycle gap.
- Frame timing:
  - busy_out is high for exactly (NB+1)*CLKDIV cycles.
  - done_out rises (NB+1)*CLKDIV+1 cycles after the accepting edge.
- Latching: words_in changes after the start edge do not affect the frame in flight.
- Counter widths: sized by $clog2 of NB+1 and of CLKDIV. No wrap occurs inside a frame, and the counters clear on frame start.
- Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- Basic frame:
  - Stimulus: NUM_WORDS=2, WORD_WIDTH=4, CLKDIV=4; words_in=8'hA5; start pulse at cycle 10.
  - Required: sdata_out sampled at each sclk rising edge reads 0,1,0,1,1,0,1,0.
  - Required: trig_out is high for cycles 43-46, busy_out is high for cycles 11-46, and done_out pulses at cycle 47.
- Default-parameter loopback:
  - Stimulus: connect to the deserializer and send 12 distinct 35-bit values, including 35'h4_0000_0000 and 35'h3_FFFF_FFFF.
  - Required: every numK output equals the sent word after the trig edge, and busy_out lasts 421*8=3368 cycles.
- Start while busy:
  - Stimulus: pulse start_in again mid-frame with different words_in.
  - Required: the frame content and length are unchanged, and only one done_out pulse occurs.
- Back-to-back frames:
  - Stimulus: hold start_in=1 continuously.
  - Required: the next frame's busy_out rises exactly 1 cycle after done_out, with a sclk-low gap of 1 cycle.
- Reset mid-frame:
  - Stimulus: drive rst_in=0 during bit 3 for 2 cycles, then a fresh start.
  - Required: all outputs are 0 the cycle after the reset edge, no trig_out or done_out comes from the aborted frame, and the new frame is complete and correct.
- Minimum divider:
  - Stimulus: CLKDIV=2, NUM_WORDS=1, WORD_WIDTH=3, word=3'b100.
  - Required: sclk_out toggles every cycle, the bits read 1,0,0, and busy_out is high for 8 cycles.

Source files
------------

// File: rtl/param_serializer.sv
// param_serializer: transmit end of the serial parameter-load link.
// Sends NUM_WORDS words (word 0 first, each MSB first) on sdata_out with a
// low-then-high sclk_out per bit. The frame ends with one trigger bit period
// and a one-cycle done_out pulse.
//
// state | meaning
// IDLE  | outputs low, waiting for start_in
// SHIFT | sending data bits, one per CLKDIV cycles
// TRIG  | one extra bit period with trig_out high and sdata_out low
// DONE  | single-cycle done_out pulse; a new start is accepted here
module param_serializer #(
    parameter int NUM_WORDS  = 12,
    parameter int WORD_WIDTH = 35,
    parameter int CLKDIV     = 8
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic [NUM_WORDS*WORD_WIDTH-1:0] words_in,
    input  logic                            start_in,
    output logic                            busy_out,
    output logic                            done_out,
    output logic                            sdata_out,
    output logic                            sclk_out,
    output logic                            trig_out
);

    localparam int NB    = NUM_WORDS * WORD_WIDTH;
    localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BIT_W = $clog2(NB + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKDIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TRIG  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [NB-1:0]     shreg_q, shreg_d;
    logic [NB-1:0]     load_w;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic sdata_q, sdata_d;
    logic sclk_q, sclk_d;
    logic trig_q, trig_d;

    // Word 0 goes to the top of the shift register so it leaves first; each
    // word keeps its own MSB-first order.
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_load
        assign load_w[NB-1-k*WORD_WIDTH -: WORD_WIDTH] = words_in[k*WORD_WIDTH +: WORD_WIDTH];
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sdata_q <= 1'b0;
            sclk_q  <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sdata_q <= sdata_d;
            sclk_q  <= sclk_d;
            trig_q  <= trig_d;
        end
    end

    // Next-state: frame acceptance, bit-period divider and bit counting.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_in) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    shreg_d = load_w;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    shreg_d = shreg_q << 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = TRIG;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TRIG: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        busy_d  = (state_d == SHIFT) || (state_d == TRIG);
        done_d  = (state_d == DONE);
        sclk_d  = busy_d && (div_d >= DIV_HALF);
        sdata_d = (state_d == SHIFT) && shreg_d[NB-1];
        trig_d  = (state_d == TRIG);
    end

    assign busy_out  = busy_q;
    assign done_out  = done_q;
    assign sdata_out = sdata_q;
    assign sclk_out  = sclk_q;
    assign trig_out  = trig_q;

endmodule

// File: tb/tb_param_serializer.sv
// Bench for param_serializer: two configurations (2x4 bits, divider 4 and
// 1x3 bits, divider 2), each with a cycle-level reference model and directed
// plus randomized stimulus.
module tb_param_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string nm, input int g, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t actual=%b required=%b", nm, g, $time, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int g, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t actual=%0d required=%0d", nm, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NW = (g == 0) ? 2 : 1;
        localparam int WW = (g == 0) ? 4 : 3;
        localparam int CD = (g == 0) ? 4 : 2;
        localparam int NB = NW * WW;
        localparam int FL = (NB + 1) * CD;
        localparam logic [NB-1:0] LIT_W    = (g == 0) ? NB'(8'hA5) : NB'(3'b100);
        localparam logic [NB-1:0] LIT_BITS = (g == 0) ? NB'(8'b01011010) : NB'(3'b100);

        logic          rst_n = 1'b0;
        logic          start = 1'b0;
        logic [NB-1:0] words = '0;
        logic          busy, done, sdata, sclk, trig;
        bit            chk_en = 1'b0;
        bit            fin_l  = 1'b0;

        param_serializer #(
            .NUM_WORDS (NW),
            .WORD_WIDTH(WW),
            .CLKDIV    (CD)
        ) u_dut (
            .clk_in   (clk),
            .rst_in   (rst_n),
            .words_in (words),
            .start_in (start),
            .busy_out (busy),
            .done_out (done),
            .sdata_out(sdata),
            .sclk_out (sclk),
            .trig_out (trig)
        );

        // Model: m_k counts cycles since the accepting edge (1 = first busy cycle).
        logic          m_act   = 1'b0;
        int            m_k     = 0;
        logic [NB-1:0] m_words = '0;

        always @(posedge clk) begin
            if (!rst_n) begin
                m_act <= 1'b0;
                m_k   <= 0;
            end else if (start && (!m_act || m_k == FL + 1)) begin
                m_act   <= 1'b1;
                m_k     <= 1;
                m_words <= words;
            end else if (m_act) begin
                if (m_k == FL + 1) m_act <= 1'b0;
                else               m_k   <= m_k + 1;
            end
        end

        int   e_b, e_p, e_idx;
        logic e_busy, e_done, e_sclk, e_sdata, e_trig;

        always @(negedge clk) begin
            if (chk_en) begin
                e_busy  = m_act && (m_k <= FL);
                e_done  = m_act && (m_k == FL + 1);
                e_b     = (m_k - 1) / CD;
                e_p     = (m_k - 1) % CD;
                e_sclk  = e_busy && (e_p >= CD / 2);
                e_trig  = e_busy && (e_b == NB);
                e_sdata = 1'b0;
                if (e_busy && e_b < NB) begin
                    e_idx   = (e_b / WW) * WW + (WW - 1 - (e_b % WW));
                    e_sdata = m_words[e_idx];
                end
                chk1("busy",  g, busy,  e_busy);
                chk1("done",  g, done,  e_done);
                chk1("sclk",  g, sclk,  e_sclk);
                chk1("sdata", g, sdata, e_sdata);
                chk1("trig",  g, trig,  e_trig);
            end
        end

        task automatic wait_done(input string nm);
            int n;
            n = 0;
            while (!done && n < FL + 40) begin
                @(negedge clk);
                n++;
            end
            chk1(nm, g, done, 1'b1);
        endtask

        initial begin
            int            nbusy, nbits, done_at, ndone, ntrig;
            logic          prev_sclk, hold;
            logic [NB-1:0] cap;

            @(posedge clk);
            chk_en = 1'b1;
            repeat (3) @(negedge clk);
            chk1("reset_busy", g, busy, 1'b0);
            chk1("reset_sclk", g, sclk, 1'b0);
            rst_n = 1'b1;

            // Directed frame with hand-computed bit sequence and timing.
            @(negedge clk);
            words = LIT_W;
            start = 1'b1;
            @(negedge clk);
            start     = 1'b0;
            nbusy     = 0;
            nbits     = 0;
            done_at   = -1;
            prev_sclk = 1'b0;
            cap       = '0;
            for (int i = 0; i < FL + 20 && done_at < 0; i++) begin
                if (busy) nbusy++;
                if (sclk && !prev_sclk) begin
                    if (nbits < NB) cap[NB-1-nbits] = sdata;
                    nbits++;
                end
                prev_sclk = sclk;
                if (done) done_at = i;
                else      @(negedge clk);
            end
            chki("lit_bits", g, int'(cap), int'(LIT_BITS));
            chki("lit_rises", g, nbits, NB + 1);
            chki("lit_busy_len", g, nbusy, FL);
            chki("lit_done_at", g, done_at, FL);

            // Start pulse while busy with different words must be ignored.
            @(negedge clk);
            words = NB'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            ndone = 0;
            for (int i = 0; i < FL + 4 * CD; i++) begin
                if (i == 2 * CD) begin
                    words = ~words;
                    start = 1'b1;
                end
                if (i == 2 * CD + 1) start = 1'b0;
                if (done) ndone++;
                @(negedge clk);
            end
            chki("busy_start_dones", g, ndone, 1);

            // Back-to-back frames with start held high.
            words = NB'($urandom);
            start = 1'b1;
            wait_done("b2b_done1");
            @(negedge clk);
            chk1("b2b_busy_gap", g, busy, 1'b1);
            chk1("b2b_sclk_gap", g, sclk, 1'b0);
            words = NB'($urandom);
            wait_done("b2b_done2");
            start = 1'b0;
            repeat (3) @(negedge clk);

            // Reset during bit 3, then a fresh frame.
            words = NB'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3 * CD + 1) @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            chk1("rst_mid_busy", g, busy, 1'b0);
            chk1("rst_mid_sclk", g, sclk, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
            ndone = 0;
            ntrig = 0;
            repeat (FL + 5) begin
                @(negedge clk);
                if (done) ndone++;
                if (trig) ntrig++;
            end
            chki("rst_abort_done", g, ndone, 0);
            chki("rst_abort_trig", g, ntrig, 0);
            words = NB'($urandom);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_done("rst_fresh_done");

            // Randomized starts, words and occasional resets.
            hold = 1'b0;
            for (int i = 0; i < 2500; i++) begin
                @(negedge clk);
                rst_n = ($urandom_range(0, 299) != 0);
                if ($urandom_range(0, 39) == 0) hold = !hold;
                start = hold || ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) == 0) words = NB'($urandom);
            end
            @(negedge clk);
            rst_n = 1'b1;
            start = 1'b0;
            repeat (FL + 5) @(negedge clk);
            fin_l = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_dut[0].fin_l && g_dut[1].fin_l) && t < 40000) begin
            @(negedge clk);
            t++;
        end
        chk1("finish_in_time", -1, g_dut[0].fin_l && g_dut[1].fin_l, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
